// File: rtl/boid_pkg.sv
// rtl/boid_pkg.sv - shared screen geometry, position widths and FSM states for the boid mover
package boid_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int STEP_W   = 12;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        EMIT,
        DONE
    } state_t;
endpackage

// File: rtl/boid_mover_if.sv
// rtl/boid_mover_if.sv - pixel address handshake between the boid mover and its consumer
interface boid_mover_if #(
    parameter int ADDR_W = 20,
    parameter int IDX_W  = 3
);
    import boid_pkg::*;

    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] address;
    logic [X_W-1:0]    x_loc;
    logic [Y_W-1:0]    y_loc;
    logic [IDX_W-1:0]  boid_idx;

    modport master (
        output addr_valid, address, x_loc, y_loc, boid_idx,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, address, x_loc, y_loc, boid_idx,
        output addr_ready
    );
endinterface

// File: rtl/boid_axis_step.sv
// rtl/boid_axis_step.sv - one-axis position step with reflection off the screen edges
module boid_axis_step
    import boid_pkg::*;
#(
    parameter int P_W   = 10,
    parameter int VEL_W = 4,
    parameter int MAX   = 639
) (
    input  logic        [P_W-1:0]   pos,
    input  logic signed [VEL_W-1:0] vel,
    output logic        [P_W-1:0]   pos_next,
    output logic signed [VEL_W-1:0] vel_next
);
    logic signed [STEP_W-1:0] pos_ext;
    logic signed [STEP_W-1:0] vel_ext;
    logic signed [STEP_W-1:0] sum;
    logic signed [STEP_W-1:0] back;

    always_comb begin
        pos_ext = $signed({{(STEP_W-P_W){1'b0}}, pos});
        vel_ext = $signed({{(STEP_W-VEL_W){vel[VEL_W-1]}}, vel});
        sum     = pos_ext + vel_ext;
        back    = pos_ext - vel_ext;
        // On a wall hit the boid bounces back by the old velocity instead of clamping.
        if (sum < 0 || sum > $signed(STEP_W'(MAX))) begin
            pos_next = back[P_W-1:0];
            vel_next = -vel;
        end else begin
            pos_next = sum[P_W-1:0];
            vel_next = vel;
        end
    end
endmodule

// File: rtl/boid_mover.sv
// rtl/boid_mover.sv - per-frame boid position update with handshaked pixel address emission
module boid_mover #(
    parameter int NUM_BOIDS  = 8,
    parameter int SCREEN_W   = boid_pkg::SCREEN_W,
    parameter int SCREEN_H   = boid_pkg::SCREEN_H,
    parameter int VEL_W      = 4,
    parameter int ADDR_W     = $clog2(SCREEN_W*SCREEN_H)+1,
    localparam int IDX_W     = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic                          load_en,
    input  logic [IDX_W-1:0]              load_idx,
    input  logic [boid_pkg::X_W-1:0]      load_x,
    input  logic [boid_pkg::Y_W-1:0]      load_y,
    input  logic signed [VEL_W-1:0]       load_dx,
    input  logic signed [VEL_W-1:0]       load_dy,
    boid_mover_if.master                  emit,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun
);
    import boid_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BOIDS-1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [X_W-1:0]          bx  [NUM_BOIDS];
    logic [Y_W-1:0]          by  [NUM_BOIDS];
    logic signed [VEL_W-1:0] bdx [NUM_BOIDS];
    logic signed [VEL_W-1:0] bdy [NUM_BOIDS];

    logic [X_W-1:0]          x_new;
    logic [Y_W-1:0]          y_new;
    logic signed [VEL_W-1:0] dx_new;
    logic signed [VEL_W-1:0] dy_new;
    logic [ADDR_W-1:0]       addr_calc;

    boid_axis_step #(.P_W(X_W), .VEL_W(VEL_W), .MAX(SCREEN_W-1)) u_step_x (
        .pos(bx[idx]), .vel(bdx[idx]), .pos_next(x_new), .vel_next(dx_new)
    );

    boid_axis_step #(.P_W(Y_W), .VEL_W(VEL_W), .MAX(SCREEN_H-1)) u_step_y (
        .pos(by[idx]), .vel(bdy[idx]), .pos_next(y_new), .vel_next(dy_new)
    );

    // 640 = 512 + 128, so the default screen needs only two shifts and an add.
    if (SCREEN_W == 640) begin : g_addr_shift
        assign addr_calc = (ADDR_W'(y_new) << 9) + (ADDR_W'(y_new) << 7) + ADDR_W'(x_new);
    end else begin : g_addr_mul
        assign addr_calc = ADDR_W'(x_new) + ADDR_W'(SCREEN_W) * ADDR_W'(y_new);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            overrun         <= 1'b0;
            emit.addr_valid <= 1'b0;
            emit.address    <= '0;
            emit.x_loc      <= '0;
            emit.y_loc      <= '0;
            emit.boid_idx   <= '0;
            for (int i = 0; i < NUM_BOIDS; i++) begin
                bx[i]  <= X_W'((40*i) % SCREEN_W);
                by[i]  <= Y_W'((30*i) % SCREEN_H);
                bdx[i] <= VEL_W'(1);
                bdy[i] <= VEL_W'(1);
            end
        end else begin
            frame_done <= 1'b0;
            overrun    <= frame_tick && busy;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        state <= UPDATE;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end else if (load_en) begin
                        bx[load_idx]  <= load_x;
                        by[load_idx]  <= load_y;
                        bdx[load_idx] <= load_dx;
                        bdy[load_idx] <= load_dy;
                    end
                end
                UPDATE: begin
                    bx[idx]         <= x_new;
                    by[idx]         <= y_new;
                    bdx[idx]        <= dx_new;
                    bdy[idx]        <= dy_new;
                    emit.x_loc      <= x_new;
                    emit.y_loc      <= y_new;
                    emit.address    <= addr_calc;
                    emit.boid_idx   <= idx;
                    emit.addr_valid <= 1'b1;
                    state           <= EMIT;
                end
                EMIT: begin
                    if (emit.addr_ready) begin
                        emit.addr_valid <= 1'b0;
                        if (idx == LAST) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= UPDATE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boid_mover.sv
// tb/tb_boid_mover.sv - self-checking bench for boid_mover with four boids
module tb_boid_mover;
    localparam int N  = 4;
    localparam int AW = 20;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              frame_tick = 1'b0;
    logic              load_en = 1'b0;
    logic [1:0]        load_idx = '0;
    logic [9:0]        load_x = '0;
    logic [8:0]        load_y = '0;
    logic signed [3:0] load_dx = '0;
    logic signed [3:0] load_dy = '0;
    logic              busy, frame_done, overrun;

    boid_mover_if #(.ADDR_W(AW), .IDX_W(2)) bus ();

    boid_mover #(.NUM_BOIDS(N)) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .load_en(load_en),
        .load_idx(load_idx), .load_x(load_x), .load_y(load_y),
        .load_dx(load_dx), .load_dy(load_dy), .emit(bus),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #10 clock = ~clock;

    int tests = 0;
    int fails = 0;

    int mx [N], my [N], mdx [N], mdy [N];
    int got_addr [N], got_x [N], got_y [N];

    typedef struct {
        int x, y, dx, dy;
        int ex, ey, eaddr;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = (40*i) % 640;  my[i] = (30*i) % 480;
            mdx[i] = 1;            mdy[i] = 1;
        end
    endfunction

    function automatic void step_axis(inout int p, inout int v, input int maxv);
        int n;
        n = p + v;
        if (n < 0 || n > maxv) begin
            p = p - v;
            v = -v;
        end else begin
            p = n;
        end
    endfunction

    task automatic load_boid(input int i, input int x, input int y, input int dx, input int dy);
        load_idx = 2'(i); load_x = 10'(x); load_y = 9'(y);
        load_dx = 4'(dx); load_dy = 4'(dy); load_en = 1'b1;
        @(negedge clock);
        load_en = 1'b0;
        mx[i] = x; my[i] = y; mdx[i] = dx; mdy[i] = dy;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready held low for the first 5 EMIT cycles.
    // disturb: a frame_tick and a load_en are driven in the middle of the pass.
    task automatic run_pass(input int mode, input bit disturb);
        int ex_addr [N], ex_x [N], ex_y [N];
        int cyc, first_busy, done_cyc, dones, overs, xfers, stall_cnt;
        int h_addr, h_x, h_y, h_idx;
        bit holding, pending, r;
        for (int i = 0; i < N; i++) begin
            step_axis(mx[i], mdx[i], 639);
            step_axis(my[i], mdy[i], 479);
            ex_x[i] = mx[i]; ex_y[i] = my[i]; ex_addr[i] = mx[i] + 640*my[i];
        end
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        cyc = 0; first_busy = -1; done_cyc = -1; dones = 0; overs = 0; xfers = 0;
        stall_cnt = 0; holding = 0; pending = 0;
        h_addr = 0; h_x = 0; h_y = 0; h_idx = 0;
        while (done_cyc < 0 && cyc < 300) begin
            if (busy && first_busy < 0) first_busy = cyc;
            if (overrun) overs++;
            if (frame_done) begin dones++; done_cyc = cyc; end
            if (pending) begin
                check("xfer_taken", int'(bus.addr_valid), 0);
                pending = 0;
            end
            if (holding) begin
                check("hold_valid", int'(bus.addr_valid), 1);
                check("hold_addr", int'(bus.address), h_addr);
                check("hold_x", int'(bus.x_loc), h_x);
                check("hold_y", int'(bus.y_loc), h_y);
                check("hold_idx", int'(bus.boid_idx), h_idx);
            end
            frame_tick = disturb && cyc == 3;
            load_en    = disturb && cyc == 2;
            load_idx = 2'd0; load_x = 10'd5; load_y = 9'd5; load_dx = 4'sd2; load_dy = 4'sd2;
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = !(bus.addr_valid && stall_cnt < 5);
            endcase
            bus.addr_ready = r;
            if (bus.addr_valid) begin
                if (r) begin
                    if (xfers < N) begin
                        check("xfer_addr", int'(bus.address), ex_addr[xfers]);
                        check("xfer_x", int'(bus.x_loc), ex_x[xfers]);
                        check("xfer_y", int'(bus.y_loc), ex_y[xfers]);
                        check("xfer_idx", int'(bus.boid_idx), xfers);
                        got_addr[xfers] = int'(bus.address);
                        got_x[xfers] = int'(bus.x_loc);
                        got_y[xfers] = int'(bus.y_loc);
                    end
                    xfers++;
                    holding = 0;
                    pending = 1;
                end else begin
                    holding = 1;
                    h_addr = int'(bus.address); h_x = int'(bus.x_loc);
                    h_y = int'(bus.y_loc); h_idx = int'(bus.boid_idx);
                    if (mode == 2) stall_cnt++;
                end
            end
            @(negedge clock);
            cyc++;
        end
        frame_tick = 1'b0;
        load_en = 1'b0;
        bus.addr_ready = 1'b0;
        check("pass_timeout", int'(done_cyc >= 0), 1);
        if (mode == 0) check("pass_cycles", done_cyc - first_busy + 1, 2*N + 1);
        if (mode == 2) check("stall_cycles", stall_cnt, 5);
        for (int k = 0; k < 3; k++) begin
            if (overrun) overs++;
            check("idle_busy", int'(busy), 0);
            check("idle_done", int'(frame_done), 0);
            @(negedge clock);
        end
        check("xfer_count", xfers, N);
        check("done_count", dones, 1);
        check("overrun_count", overs, disturb ? 1 : 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        vecs[0] = '{x:639, y:0,   dx:1,  dy:-2, ex:638, ey:2,   eaddr:1918};
        vecs[1] = '{x:0,   y:479, dx:-3, dy:2,  ex:3,   ey:477, eaddr:305283};
        vecs[2] = '{x:100, y:200, dx:5,  dy:-5, ex:105, ey:195, eaddr:124905};
        vecs[3] = '{x:635, y:475, dx:7,  dy:7,  ex:628, ey:468, eaddr:300148};
        vecs[4] = '{x:0,   y:0,   dx:0,  dy:0,  ex:0,   ey:0,   eaddr:0};
        vecs[5] = '{x:639, y:479, dx:0,  dy:-8, ex:639, ey:471, eaddr:302079};

        bus.addr_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_valid", int'(bus.addr_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_addr", int'(bus.address), 0);
        check("rst_x", int'(bus.x_loc), 0);
        check("rst_y", int'(bus.y_loc), 0);
        check("rst_idx", int'(bus.boid_idx), 0);
        reset = 1'b0;
        model_reset();

        run_pass(0, 0);
        check("first_addr0", got_addr[0], 641);
        check("first_addr1", got_addr[1], 19881);
        check("first_addr2", got_addr[2], 39121);
        check("first_addr3", got_addr[3], 58361);

        foreach (vecs[v]) begin
            load_boid(0, vecs[v].x, vecs[v].y, vecs[v].dx, vecs[v].dy);
            run_pass(0, 0);
            check("vec_x", got_x[0], vecs[v].ex);
            check("vec_y", got_y[0], vecs[v].ey);
            check("vec_addr", got_addr[0], vecs[v].eaddr);
        end

        load_boid(0, 639, 0, 1, -2);
        run_pass(0, 0);
        check("bounce_x1", got_x[0], 638);
        check("bounce_y1", got_y[0], 2);
        run_pass(0, 0);
        check("bounce_x2", got_x[0], 637);
        check("bounce_y2", got_y[0], 4);

        run_pass(2, 0);
        run_pass(0, 1);
        run_pass(0, 0);

        // reset during the second EMIT aborts the pass
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (bus.addr_valid && bus.boid_idx == 2'd1) begin
                seen = 1;
            end else begin
                bus.addr_ready = 1'b1;
                @(negedge clock);
            end
        end
        check("second_emit_seen", seen, 1);
        bus.addr_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(frame_done), 0);
        check("abort_valid", int'(bus.addr_valid), 0);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        check("abort_no_done", int'(frame_done), 0);
        run_pass(0, 0);
        check("after_abort_addr0", got_addr[0], 641);

        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < N; i++)
                load_boid(i, $urandom_range(0, 639), $urandom_range(0, 479),
                          int'($urandom_range(0, 14)) - 7, int'($urandom_range(0, 14)) - 7);
            run_pass(1, 0);
            run_pass(1, it == 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/boid_mover.md
BOID_MOVER -- requirements
Module: boid_mover

Interface
REQ-001 Parameter NUM_BOIDS, default 8: boids held internally (1..64).
REQ-002 Parameter SCREEN_W, default 640: screen width in pixels.
REQ-003 Parameter SCREEN_H, default 480: screen height in pixels.
REQ-004 Parameter VEL_W, default 4: signed velocity width per axis.
REQ-005 Parameter ADDR_W, default $clog2(SCREEN_W*SCREEN_H)+1: pixel address width.
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 clock  input  1  system clock, 50 MHz.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 frame_tick  input  1  single-cycle pulse that requests one update pass over all boids.
REQ-010 load_en  input  1  writes the boid state at load_idx; honoured only in IDLE.
REQ-011 load_idx  input  $clog2(NUM_BOIDS)  index of the boid to load.
REQ-012 load_x / load_y  input  10 / 9  position to load.
REQ-013 load_dx / load_dy  input  VEL_W each  signed velocity to load.
REQ-014 addr_valid  output  1  address, x_loc and y_loc are valid.
REQ-015 addr_ready  input  1  consumer accepts the address.
REQ-016 address  output  ADDR_W  pixel address, x_loc + SCREEN_W*y_loc.
REQ-017 x_loc / y_loc  output  10 / 9  updated boid position.
REQ-018 boid_idx  output  $clog2(NUM_BOIDS)  index of the boid being emitted.
REQ-019 busy  output  1  high while a pass is in progress.
REQ-020 frame_done  output  1  single-cycle pulse when a pass completes.
REQ-021 overrun  output  1  single-cycle pulse when frame_tick arrives while busy.

Function
REQ-022 The FSM states shall be IDLE, UPDATE, EMIT and DONE.
REQ-023 IDLE: frame_tick shall go to UPDATE with idx=0 on the next cycle; otherwise load_en writes the state at load_idx.
REQ-024 UPDATE (1 cycle): boid[idx] shall be computed and written back; next state EMIT.
REQ-025 Per axis: n = p + v in signed 12-bit arithmetic; if n<0 or n>MAX (SCREEN_W-1 or SCREEN_H-1) then v := -v and p := p - v_old, else p := n.
REQ-026 EMIT: addr_valid=1; address/x_loc/y_loc/boid_idx shall be held stable until addr_valid & addr_ready.
REQ-027 On transfer, go to UPDATE with idx+1, or to DONE if idx = NUM_BOIDS-1.
REQ-028 DONE: frame_done=1 for one cycle, then IDLE.
REQ-029 busy shall be 1 in UPDATE, EMIT and DONE.
REQ-030 frame_tick while busy: ignored; overrun=1 the following cycle; no pass is queued.
REQ-031 load_en while busy: ignored with no state change.
REQ-032 address shall be computed as (y<<9)+(y<<7)+x when SCREEN_W=640, and by a generic multiply otherwise.
REQ-033 Minimum pass time: 2*NUM_BOIDS+1 cycles after the first UPDATE cycle, with addr_ready held high.

Reset
REQ-034 Reset shall give state IDLE, idx 0, and addr_valid, busy, frame_done and overrun all 0.
REQ-035 Reset shall drive address, x_loc, y_loc and boid_idx to 0.
REQ-036 Reset shall initialise boid i to x=(40*i) mod SCREEN_W, y=(30*i) mod SCREEN_H, dx=+1, dy=+1.
REQ-037 Reset mid-pass shall abort the pass without emitting frame_done, and reinitialise per REQ-036.

Structure
REQ-038 A shared package boid_pkg shall hold SCREEN_W, SCREEN_H, the position widths and the state enum.
REQ-039 The per-axis reflect arithmetic shall be a sub-module, boid_axis_step, instanced for x and y.

Verification (NUM_BOIDS=4, default parameters)
REQ-040 Reset, frame_tick, addr_ready=1 -> four transfers with addresses 641, 19881, 39121, 58361; frame_done 9 cycles after the first UPDATE cycle.
REQ-041 Load boid0 x=639, dx=+1, then frame_tick -> x_loc=638, next pass 637; boid0 y=0, dy=-2 -> y=2, dy=+2.
REQ-042 addr_ready low for 5 cycles during EMIT -> addr_valid stays high and address is unchanged; transfer occurs on the cycle ready rises.
REQ-043 frame_tick during a pass -> exactly one overrun pulse, no extra pass, and four transfers total.
REQ-044 Reset asserted in the 2nd EMIT -> next cycle busy=0, no frame_done; next pass re-emits 641 first.
REQ-045 load_en while busy -> no effect, confirmed by the emitted addresses of the next pass.
